// File: rtl/button_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
package button_pkg;

   // Debouncer FSM states.
   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } btn_state_t;

   // Width of a counter that must reach the larger of the two cycle limits.
   function automatic int calc_dw(input int deb_cycles, input int long_cycles);
      int m;
      m = (deb_cycles > long_cycles) ? deb_cycles : long_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin; reusable for any input.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Shift the raw pin through two flops to settle metastability.
   // NOTE: non-blocking assignments keep the two stages as separate flops; a
   // blocking pair would collapse into one register in simulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Debounces one raw pushbutton into a clean level, press/release/long-press
// pulses and a wrapping press counter. All outputs are registered.
module button_debounce
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120_000,
   parameter int LONG_CYCLES     = 12_000_000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_btn_in,
   output logic             o_btn_level,
   output logic             o_press,
   output logic             o_release,
   output logic             o_long_press,
   output logic [CNT_W-1:0] o_press_count
);

   localparam int            DW        = calc_dw(DEBOUNCE_CYCLES, LONG_CYCLES);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] HOLD_LAST = DW'(LONG_CYCLES - 1);

   logic             w_btn_sync;
   logic             w_act;

   btn_state_t       r_state;
   logic [DW-1:0]    r_deb_cnt;
   logic [DW-1:0]    r_hold_cnt;
   logic             r_long_done;
   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic             r_long_press;
   logic [CNT_W-1:0] r_press_count;

   sync_2ff #(
      .RESET_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (i_btn_in),
      .o_q (w_btn_sync)
   );

   // Normalise polarity so 1 always means "pressed".
   assign w_act = w_btn_sync ^ ACTIVE_LOW;

   // Stability FSM with debounce and hold counters; pulses default low each cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= RELEASED;
         r_deb_cnt     <= '0;
         r_hold_cnt    <= '0;
         r_long_done   <= 1'b0;
         r_level       <= 1'b0;
         r_press       <= 1'b0;
         r_release     <= 1'b0;
         r_long_press  <= 1'b0;
         r_press_count <= '0;
      end else begin
         r_press      <= 1'b0;
         r_release    <= 1'b0;
         r_long_press <= 1'b0;

         case (r_state)
            RELEASED: begin
               if (w_act) begin
                  r_state   <= PRESS_PEND;
                  r_deb_cnt <= '0;
               end
            end

            PRESS_PEND: begin
               if (!w_act) begin
                  // Too short to be a press: drop it silently.
                  r_state <= RELEASED;
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_state       <= PRESSED;
                  r_press       <= 1'b1;
                  r_level       <= 1'b1;
                  r_press_count <= r_press_count + 1'b1;
                  r_hold_cnt    <= '0;
                  r_long_done   <= 1'b0;
               end else begin
                  r_deb_cnt <= r_deb_cnt + 1'b1;
               end
            end

            PRESSED: begin
               if (r_hold_cnt != HOLD_LAST) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
               if ((r_hold_cnt == HOLD_LAST) && !r_long_done) begin
                  r_long_press <= 1'b1;
                  r_long_done  <= 1'b1;
               end
               // Leaving for RELEASE_PEND does not cancel a long press fired this cycle.
               if (!w_act) begin
                  r_state   <= RELEASE_PEND;
                  r_deb_cnt <= '0;
               end
            end

            RELEASE_PEND: begin
               // hold_cnt stays frozen here so a bounce does not advance the long timer.
               if (w_act) begin
                  r_state <= PRESSED;
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_state   <= RELEASED;
                  r_release <= 1'b1;
                  r_level   <= 1'b0;
               end else begin
                  r_deb_cnt <= r_deb_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= RELEASED;
            end
         endcase
      end
   end

   assign o_btn_level   = r_level;
   assign o_press       = r_press;
   assign o_release     = r_release;
   assign o_long_press  = r_long_press;
   assign o_press_count = r_press_count;

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce (DEBOUNCE=4, LONG=20, active-low pin).
module tb_button_debounce;

   localparam int DEB   = 4;
   localparam int LONG  = 20;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             btn_in;
   logic             btn_level;
   logic             press;
   logic             rel;
   logic             long_press;
   logic [CNT_W-1:0] press_count;

   int n_cmp;
   int n_err;
   int cyc;
   int n_press, n_rel, n_long;
   int press_cyc, rel_cyc, long_cyc;
   int t0;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LONG),
      .ACTIVE_LOW      (1'b1),
      .CNT_W           (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_btn_in      (btn_in),
      .o_btn_level   (btn_level),
      .o_press       (press),
      .o_release     (rel),
      .o_long_press  (long_press),
      .o_press_count (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_counts();
      n_press   = 0;
      n_rel     = 0;
      n_long    = 0;
      press_cyc = -1;
      rel_cyc   = -1;
      long_cyc  = -1;
   endtask

   // Drive the pin, wait one rising edge, then sample outputs 1 time unit later.
   task automatic tick(input logic b);
      btn_in = b;
      @(posedge clk);
      #1;
      cyc++;
      if (press)      begin n_press++; press_cyc = cyc; end
      if (rel)        begin n_rel++;   rel_cyc   = cyc; end
      if (long_press) begin n_long++;  long_cyc  = cyc; end
   endtask

   task automatic run(input logic b, input int n);
      for (int i = 0; i < n; i++) tick(b);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run(1'b1, 3);
      rst = 1'b0;
      run(1'b1, 3);
      clear_counts();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      rst   = 1'b1;
      btn_in = 1'b1;
      clear_counts();
      do_reset();

      // Reset state
      check("rst_level", btn_level, 0);
      check("rst_count", press_count, 0);
      check("rst_pulses", press | rel | long_press, 0);

      // Clean press: 12 cycles low then high
      t0 = cyc + 1;
      run(1'b0, 12);
      check("clean_press_edge", press_cyc - t0 + 1, 7);
      check("clean_level_held", btn_level, 1);
      check("clean_count", press_count, 1);
      t0 = cyc + 1;
      run(1'b1, 12);
      check("clean_rel_edge", rel_cyc - t0 + 1, 7);
      check("clean_n_press", n_press, 1);
      check("clean_n_rel", n_rel, 1);
      check("clean_n_long", n_long, 0);
      check("clean_level_after", btn_level, 0);

      // Glitch: 3 cycles low
      do_reset();
      run(1'b0, 3);
      run(1'b1, 12);
      check("glitch_n_press", n_press, 0);
      check("glitch_n_rel", n_rel, 0);
      check("glitch_level", btn_level, 0);
      check("glitch_count", press_count, 0);

      // Bouncy press: L L H repeating for 10 cycles, then 30 low
      do_reset();
      for (int i = 0; i < 10; i++) tick((i % 3) == 2);
      check("bounce_no_early_press", n_press, 0);
      run(1'b0, 30);
      run(1'b1, 12);
      check("bounce_n_press", n_press, 1);
      check("bounce_n_long", n_long, 1);
      check("bounce_long_gap", long_cyc - press_cyc, LONG);
      check("bounce_count", press_count, 1);
      check("bounce_n_rel", n_rel, 1);

      // Long press with a 2-cycle blip at cycles 15-16 of a 40-cycle hold
      do_reset();
      run(1'b0, 14);
      run(1'b1, 2);
      run(1'b0, 4);
      check("blip_level", btn_level, 1);
      check("blip_no_rel", n_rel, 0);
      run(1'b0, 20);
      check("blip_no_rel_end", n_rel, 0);
      check("blip_n_long", n_long, 1);
      check("blip_long_gap", long_cyc - press_cyc, LONG + 2);
      run(1'b1, 12);
      check("blip_n_rel", n_rel, 1);
      check("blip_n_press", n_press, 1);

      // Counter wrap: 17 clean presses
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         run(1'b0, 8);
         run(1'b1, 10);
         check($sformatf("wrap_cnt_%0d", i), press_count, i % 16);
      end
      check("wrap_n_press", n_press, 17);
      check("wrap_n_rel", n_rel, 17);

      // Reset while PRESSED
      do_reset();
      run(1'b0, 10);
      check("rp_pre_level", btn_level, 1);
      rst = 1'b1;
      #1;
      check("rp_async_level", btn_level, 0);
      check("rp_async_count", press_count, 0);
      check("rp_async_pulses", press | rel | long_press, 0);
      clear_counts();
      run(1'b0, 2);
      rst = 1'b0;
      t0 = cyc + 1;
      run(1'b0, 10);
      check("rp_no_rel", n_rel, 0);
      check("rp_n_press", n_press, 1);
      check("rp_press_edge", press_cyc - t0 + 1, 7);
      check("rp_count", press_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
